// File: rtl/uno_player_hand_if.sv
// Controller/deck-facing signal bundle of one UNO player hand.
// The slave modport is the hand's view; master is the controller/deck side.
interface uno_player_hand_if #(
    parameter int MAX_CARDS = 24,
    parameter int CW        = $clog2(MAX_CARDS + 1)
);
    logic          i_deal;
    logic [2:0]    i_draw_req;
    logic          i_play;
    logic [CW-1:0] i_sel_idx;
    logic [5:0]    i_top_card;
    logic [CW-1:0] i_view_idx;
    logic          i_deck_done;
    logic          i_deck_drawn;
    logic [5:0]    i_deck_card;
    logic [2:0]    o_draw;
    logic          o_insert;
    logic [5:0]    o_prev_card;
    logic          o_play_ok;
    logic          o_play_reject;
    logic [CW-1:0] o_count;
    logic [5:0]    o_view_card;
    logic          o_busy;
    logic          o_uno;
    logic          o_overflow;

    modport slave (
        input  i_deal, i_draw_req, i_play, i_sel_idx, i_top_card, i_view_idx,
               i_deck_done, i_deck_drawn, i_deck_card,
        output o_draw, o_insert, o_prev_card, o_play_ok, o_play_reject,
               o_count, o_view_card, o_busy, o_uno, o_overflow
    );

    modport master (
        output i_deal, i_draw_req, i_play, i_sel_idx, i_top_card, i_view_idx,
               i_deck_done, i_deck_drawn, i_deck_card,
        input  o_draw, o_insert, o_prev_card, o_play_ok, o_play_reject,
               o_count, o_view_card, o_busy, o_uno, o_overflow
    );
endinterface

// File: rtl/uno_player_hand.sv
// Per-player UNO hand: draws cards from the deck, runs the opening 7-card deal,
// checks plays against the discard top and hands played cards back to the deck.
module uno_player_hand #(
    parameter int MAX_CARDS = 24,
    parameter int CW        = $clog2(MAX_CARDS + 1)
) (
    input logic              i_clk,
    input logic              i_rst_n,
    uno_player_hand_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, DRAW, PLAY_WAIT} state_t;

    state_t        state;
    state_t        state_next;
    logic [5:0]    hand [MAX_CARDS];
    logic [CW-1:0] count;
    logic [2:0]    code;
    logic [2:0]    need;
    logic [1:0]    deal_left;
    logic [5:0]    prev_card;
    logic          play_ok;
    logic          play_reject;
    logic          overflow;

    logic          draw_valid;
    logic          play_go;
    logic          legal;
    logic          last_strobe;
    logic [5:0]    sel_card;
    logic [5:0]    view_card;

    function automatic logic [2:0] need_for(input logic [2:0] c);
        case (c)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            3'b100:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    always_comb begin
        sel_card  = '0;
        view_card = '0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (bus.i_sel_idx == CW'(i))
                sel_card = hand[i];
            if (bus.i_view_idx == CW'(i) && CW'(i) < count)
                view_card = hand[i];
        end
    end

    // Wild cards always go; a wild on top can only be followed by colour.
    assign draw_valid  = need_for(bus.i_draw_req) != 3'd0;
    assign play_go     = (state == IDLE) && bus.i_play && !bus.i_deal && !draw_valid;
    assign legal       = (bus.i_sel_idx < count) &&
                         ((sel_card[3:0] >= 4'd13) ||
                          (sel_card[5:4] == bus.i_top_card[5:4]) ||
                          ((bus.i_top_card[3:0] < 4'd13) && (sel_card[3:0] == bus.i_top_card[3:0])));
    assign last_strobe = (state == DRAW) && bus.i_deck_drawn && (need == 3'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_deal || draw_valid)
                    state_next = REQ;
                else if (play_go && legal)
                    state_next = PLAY_WAIT;
            end
            REQ:       if (bus.i_deck_done) state_next = DRAW;
            DRAW:      if (last_strobe) state_next = (deal_left != 2'd0) ? REQ : IDLE;
            PLAY_WAIT: if (bus.i_deck_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_draw   = 3'b000;
        bus.o_insert = 1'b0;
        bus.o_busy   = (state != IDLE);
        if (state == DRAW)
            bus.o_draw = code;
        if (state == PLAY_WAIT && bus.i_deck_done)
            bus.o_insert = 1'b1;
    end

    // The deal walks the codes 100 -> 010 -> 001 by shifting the latched code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_CARDS; i++)
                hand[i] <= '0;
            count       <= '0;
            code        <= '0;
            need        <= '0;
            deal_left   <= '0;
            prev_card   <= '0;
            play_ok     <= 1'b0;
            play_reject <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            play_ok     <= play_go && legal;
            play_reject <= bus.i_play && !(play_go && legal);
            if (state == IDLE && bus.i_deal) begin
                count     <= '0;
                overflow  <= 1'b0;
                code      <= 3'b100;
                need      <= 3'd4;
                deal_left <= 2'd2;
            end else if (state == IDLE && draw_valid) begin
                code      <= bus.i_draw_req;
                need      <= need_for(bus.i_draw_req);
                deal_left <= 2'd0;
            end else if (play_go && legal) begin
                prev_card <= sel_card;
                for (int i = 0; i < MAX_CARDS - 1; i++)
                    if (CW'(i) >= bus.i_sel_idx && CW'(i + 1) < count)
                        hand[i] <= hand[i + 1];
                count <= count - 1'b1;
            end else if (state == DRAW && bus.i_deck_drawn) begin
                if (count < CW'(MAX_CARDS)) begin
                    for (int i = 0; i < MAX_CARDS; i++)
                        if (count == CW'(i))
                            hand[i] <= bus.i_deck_card;
                    count <= count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
                need <= need - 1'b1;
                if (need == 3'd1 && deal_left != 2'd0) begin
                    code      <= code >> 1;
                    need      <= need_for(code >> 1);
                    deal_left <= deal_left - 1'b1;
                end
            end
        end
    end

    assign bus.o_count       = count;
    assign bus.o_uno         = (count == CW'(1));
    assign bus.o_view_card   = view_card;
    assign bus.o_prev_card   = prev_card;
    assign bus.o_play_ok     = play_ok;
    assign bus.o_play_reject = play_reject;
    assign bus.o_overflow    = overflow;

endmodule

// File: tb/tb_uno_player_hand.sv
// Directed self-checking bench for uno_player_hand: a 24-card hand for the
// deal/play/draw scenarios and an 8-card hand for the overflow case.
module tb_uno_player_hand;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_passed = 0;

    always #5 clk = ~clk;

    uno_player_hand_if #(.MAX_CARDS(24)) hb ();
    uno_player_hand_if #(.MAX_CARDS(8))  hs ();

    uno_player_hand #(.MAX_CARDS(24)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(hb));
    uno_player_hand #(.MAX_CARDS(8))  dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(hs));

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_b(input logic [5:0] c);
        hb.i_deck_drawn = 1'b1;
        hb.i_deck_card  = c;
        tick();
        hb.i_deck_drawn = 1'b0;
        hb.i_deck_card  = '0;
    endtask

    task automatic strobe_s(input logic [5:0] c);
        hs.i_deck_drawn = 1'b1;
        hs.i_deck_card  = c;
        tick();
        hs.i_deck_drawn = 1'b0;
        hs.i_deck_card  = '0;
    endtask

    task automatic wait_draw_b(output logic [2:0] code, output bit tmo);
        tmo  = 1'b1;
        code = '0;
        for (int c = 0; c < 20; c++) begin
            if (hb.o_draw !== 3'b000) begin
                code = hb.o_draw;
                tmo  = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_draw_s(output logic [2:0] code, output bit tmo);
        tmo  = 1'b1;
        code = '0;
        for (int c = 0; c < 20; c++) begin
            if (hs.o_draw !== 3'b000) begin
                code = hs.o_draw;
                tmo  = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        hb.i_deal = 0; hb.i_draw_req = 0; hb.i_play = 0; hb.i_sel_idx = 0; hb.i_top_card = 0;
        hb.i_view_idx = 0; hb.i_deck_done = 1; hb.i_deck_drawn = 0; hb.i_deck_card = 0;
        hs.i_deal = 0; hs.i_draw_req = 0; hs.i_play = 0; hs.i_sel_idx = 0; hs.i_top_card = 0;
        hs.i_view_idx = 0; hs.i_deck_done = 1; hs.i_deck_drawn = 0; hs.i_deck_card = 0;
        rst_n = 1'b0;
        #2;
        n_checks++; if (hb.o_count !== 5'd0) $display("[TB] FAIL rst_count: got %0d want 0", hb.o_count); else n_passed++;
        n_checks++; if (hb.o_busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", hb.o_busy); else n_passed++;
        n_checks++; if (hb.o_draw !== 3'b000) $display("[TB] FAIL rst_draw: got %b want 000", hb.o_draw); else n_passed++;
        n_checks++; if (hb.o_overflow !== 1'b0) $display("[TB] FAIL rst_overflow: got %b want 0", hb.o_overflow); else n_passed++;
        n_checks++; if (hb.o_prev_card !== 6'h00) $display("[TB] FAIL rst_prev: got %h want 00", hb.o_prev_card); else n_passed++;
        n_checks++; if (hb.o_uno !== 1'b0) $display("[TB] FAIL rst_uno: got %b want 0", hb.o_uno); else n_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject, hb.o_insert} !== 3'b000)
            $display("[TB] FAIL rst_pulses: got %b want 000", {hb.o_play_ok, hb.o_play_reject, hb.o_insert}); else n_passed++;
    endtask

    task automatic test_deal();
        logic [5:0] cards [7];
        logic [2:0] exp_code [3];
        int         exp_n [3];
        logic [2:0] code;
        bit         tmo;
        int         idx;
        cards    = '{6'h03, 6'h15, 6'h20, 6'h3C, 6'h0D, 6'h19, 6'h27};
        exp_code = '{3'b100, 3'b010, 3'b001};
        exp_n    = '{4, 2, 1};
        idx = 0;
        hb.i_deal = 1'b1;
        tick();
        hb.i_deal = 1'b0;
        #1;
        n_checks++; if (hb.o_busy !== 1'b1) $display("[TB] FAIL deal_busy_start: got %b want 1", hb.o_busy); else n_passed++;
        for (int s = 0; s < 3; s++) begin
            wait_draw_b(code, tmo);
            n_checks++; if (tmo || code !== exp_code[s])
                $display("[TB] FAIL deal_code%0d: got %b (timeout %0d) want %b", s, code, tmo, exp_code[s]); else n_passed++;
            for (int k = 0; k < exp_n[s]; k++) begin
                strobe_b(cards[idx]);
                idx++;
                if (idx == 1) begin
                    n_checks++; if (hb.o_uno !== 1'b1) $display("[TB] FAIL deal_uno: got %b want 1", hb.o_uno); else n_passed++;
                end
            end
            #1;
            n_checks++; if (hb.o_draw !== 3'b000) $display("[TB] FAIL deal_release%0d: got %b want 000", s, hb.o_draw); else n_passed++;
            n_checks++; if (hb.o_busy !== (s != 2)) $display("[TB] FAIL deal_busy%0d: got %b want %b", s, hb.o_busy, s != 2); else n_passed++;
        end
        n_checks++; if (hb.o_count !== 5'd7) $display("[TB] FAIL deal_count: got %0d want 7", hb.o_count); else n_passed++;
        hb.i_view_idx = 5'd3;
        #1;
        n_checks++; if (hb.o_view_card !== 6'h3C) $display("[TB] FAIL deal_view3: got %h want 3c", hb.o_view_card); else n_passed++;
        hb.i_view_idx = 5'd6;
        #1;
        n_checks++; if (hb.o_view_card !== 6'h27) $display("[TB] FAIL deal_view6: got %h want 27", hb.o_view_card); else n_passed++;
        hb.i_view_idx = 5'd7;
        #1;
        n_checks++; if (hb.o_view_card !== 6'h00) $display("[TB] FAIL deal_view7: got %h want 00", hb.o_view_card); else n_passed++;
        tick();
    endtask

    task automatic test_plays();
        hb.i_top_card  = 6'h19;
        hb.i_deck_done = 1'b0;
        hb.i_sel_idx = 5'd6; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject} !== 2'b01)
            $display("[TB] FAIL play_g7: got ok/rej %b want 01", {hb.o_play_ok, hb.o_play_reject}); else n_passed++;
        n_checks++; if (hb.o_count !== 5'd7) $display("[TB] FAIL play_g7_count: got %0d want 7", hb.o_count); else n_passed++;
        tick();
        n_checks++; if (hb.o_play_reject !== 1'b0) $display("[TB] FAIL reject_pulse: got %b want 0", hb.o_play_reject); else n_passed++;
        hb.i_sel_idx = 5'd5; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject} !== 2'b10)
            $display("[TB] FAIL play_y9: got ok/rej %b want 10", {hb.o_play_ok, hb.o_play_reject}); else n_passed++;
        n_checks++; if (hb.o_count !== 5'd6) $display("[TB] FAIL play_y9_count: got %0d want 6", hb.o_count); else n_passed++;
        n_checks++; if (hb.o_prev_card !== 6'h19) $display("[TB] FAIL play_y9_prev: got %h want 19", hb.o_prev_card); else n_passed++;
        hb.i_view_idx = 5'd5;
        #1;
        n_checks++; if (hb.o_view_card !== 6'h27) $display("[TB] FAIL play_shift: got %h want 27", hb.o_view_card); else n_passed++;
        tick();
        n_checks++; if ({hb.o_insert, hb.o_busy, hb.o_play_ok} !== 3'b010)
            $display("[TB] FAIL play_wait: got ins/busy/ok %b want 010", {hb.o_insert, hb.o_busy, hb.o_play_ok}); else n_passed++;
        hb.i_deck_done = 1'b1;
        #1;
        n_checks++; if (hb.o_insert !== 1'b1) $display("[TB] FAIL insert_pulse: got %b want 1", hb.o_insert); else n_passed++;
        tick();
        n_checks++; if ({hb.o_insert, hb.o_busy} !== 2'b00)
            $display("[TB] FAIL insert_done: got ins/busy %b want 00", {hb.o_insert, hb.o_busy}); else n_passed++;
        n_checks++; if (hb.o_prev_card !== 6'h19) $display("[TB] FAIL prev_hold: got %h want 19", hb.o_prev_card); else n_passed++;
        hb.i_top_card = 6'h27;
        hb.i_sel_idx = 5'd6; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject} !== 2'b01)
            $display("[TB] FAIL play_out_of_range: got ok/rej %b want 01", {hb.o_play_ok, hb.o_play_reject}); else n_passed++;
        tick();
    endtask

    task automatic test_draw();
        logic [2:0] code;
        bit         tmo;
        hb.i_deck_done = 1'b0;
        hb.i_draw_req  = 3'b010;
        tick();
        hb.i_draw_req = 3'b000;
        tick();
        n_checks++; if ({hb.o_busy, hb.o_draw} !== 4'b1000)
            $display("[TB] FAIL draw_req_wait: got busy/draw %b want 1000", {hb.o_busy, hb.o_draw}); else n_passed++;
        hb.i_deck_done = 1'b1;
        wait_draw_b(code, tmo);
        n_checks++; if (tmo || code !== 3'b010) $display("[TB] FAIL draw_code: got %b (timeout %0d) want 010", code, tmo); else n_passed++;
        strobe_b(6'h22);
        n_checks++; if (hb.o_draw !== 3'b010) $display("[TB] FAIL draw_hold: got %b want 010", hb.o_draw); else n_passed++;
        strobe_b(6'h34);
        #1;
        n_checks++; if ({hb.o_busy, hb.o_draw} !== 4'b0000)
            $display("[TB] FAIL draw_release: got busy/draw %b want 0000", {hb.o_busy, hb.o_draw}); else n_passed++;
        n_checks++; if (hb.o_count !== 5'd8) $display("[TB] FAIL draw_count: got %0d want 8", hb.o_count); else n_passed++;
        hb.i_view_idx = 5'd7;
        #1;
        n_checks++; if (hb.o_view_card !== 6'h34) $display("[TB] FAIL draw_view7: got %h want 34", hb.o_view_card); else n_passed++;
        tick();
    endtask

    task automatic test_wild();
        hb.i_top_card = 6'h3D;
        hb.i_sel_idx = 5'd4; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_insert, hb.o_prev_card} !== {2'b11, 6'h0D})
            $display("[TB] FAIL wild_r13: got ok/ins/prev %b/%b/%h want 1/1/0d", hb.o_play_ok, hb.o_insert, hb.o_prev_card); else n_passed++;
        tick();
        hb.i_sel_idx = 5'd5; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject} !== 2'b01)
            $display("[TB] FAIL wild_g2: got ok/rej %b want 01", {hb.o_play_ok, hb.o_play_reject}); else n_passed++;
        hb.i_sel_idx = 5'd6; hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_prev_card} !== {1'b1, 6'h34})
            $display("[TB] FAIL wild_b4: got ok/prev %b/%h want 1/34", hb.o_play_ok, hb.o_prev_card); else n_passed++;
        n_checks++; if (hb.o_count !== 5'd6) $display("[TB] FAIL wild_count: got %0d want 6", hb.o_count); else n_passed++;
        tick();
    endtask

    task automatic test_collision();
        logic [2:0] code;
        bit         tmo;
        hb.i_top_card = 6'h03;
        hb.i_sel_idx  = 5'd0;
        hb.i_draw_req = 3'b001; hb.i_play = 1'b1;
        tick();
        hb.i_draw_req = 3'b000; hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject, hb.o_busy} !== 3'b011)
            $display("[TB] FAIL collide: got ok/rej/busy %b want 011", {hb.o_play_ok, hb.o_play_reject, hb.o_busy}); else n_passed++;
        wait_draw_b(code, tmo);
        n_checks++; if (tmo || code !== 3'b001) $display("[TB] FAIL collide_code: got %b (timeout %0d) want 001", code, tmo); else n_passed++;
        hb.i_play = 1'b1;
        tick();
        hb.i_play = 1'b0;
        #1;
        n_checks++; if ({hb.o_play_ok, hb.o_play_reject, hb.o_count} !== {2'b01, 5'd6})
            $display("[TB] FAIL busy_play: got ok/rej/count %b/%b/%0d want 0/1/6", hb.o_play_ok, hb.o_play_reject, hb.o_count); else n_passed++;
        strobe_b(6'h11);
        #1;
        n_checks++; if ({hb.o_busy, hb.o_count} !== {1'b0, 5'd7})
            $display("[TB] FAIL collide_draw: got busy/count %b/%0d want 0/7", hb.o_busy, hb.o_count); else n_passed++;
        strobe_b(6'h2A);
        #1;
        n_checks++; if (hb.o_count !== 5'd7) $display("[TB] FAIL stray_strobe: got %0d want 7", hb.o_count); else n_passed++;
        hb.i_draw_req = 3'b011;
        tick();
        hb.i_draw_req = 3'b000;
        #1;
        n_checks++; if (hb.o_busy !== 1'b0) $display("[TB] FAIL bad_code: got busy %b want 0", hb.o_busy); else n_passed++;
    endtask

    task automatic test_overflow();
        logic [2:0] code;
        bit         tmo;
        int         exp_n [3];
        exp_n = '{4, 2, 1};
        hs.i_deal = 1'b1;
        tick();
        hs.i_deal = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wait_draw_s(code, tmo);
            for (int k = 0; k < exp_n[s]; k++)
                strobe_s(6'h10 + 6'(k));
        end
        #1;
        n_checks++; if ({hs.o_count, hs.o_overflow} !== {4'd7, 1'b0})
            $display("[TB] FAIL ovf_deal: got count/ovf %0d/%b want 7/0", hs.o_count, hs.o_overflow); else n_passed++;
        hs.i_draw_req = 3'b100;
        tick();
        hs.i_draw_req = 3'b000;
        wait_draw_s(code, tmo);
        n_checks++; if (tmo || code !== 3'b100) $display("[TB] FAIL ovf_code: got %b (timeout %0d) want 100", code, tmo); else n_passed++;
        strobe_s(6'h2B);
        n_checks++; if ({hs.o_count, hs.o_overflow} !== {4'd8, 1'b0})
            $display("[TB] FAIL ovf_first: got count/ovf %0d/%b want 8/0", hs.o_count, hs.o_overflow); else n_passed++;
        strobe_s(6'h31);
        n_checks++; if ({hs.o_count, hs.o_overflow, hs.o_draw} !== {4'd8, 1'b1, 3'b100})
            $display("[TB] FAIL ovf_drop: got count/ovf/draw %0d/%b/%b want 8/1/100", hs.o_count, hs.o_overflow, hs.o_draw); else n_passed++;
        strobe_s(6'h32);
        n_checks++; if (hs.o_draw !== 3'b100) $display("[TB] FAIL ovf_hold: got %b want 100", hs.o_draw); else n_passed++;
        strobe_s(6'h33);
        #1;
        n_checks++; if ({hs.o_draw, hs.o_busy, hs.o_count, hs.o_overflow} !== {3'b000, 1'b0, 4'd8, 1'b1})
            $display("[TB] FAIL ovf_end: got draw/busy/count/ovf %b/%b/%0d/%b want 000/0/8/1", hs.o_draw, hs.o_busy, hs.o_count, hs.o_overflow); else n_passed++;
        hs.i_view_idx = 4'd7;
        #1;
        n_checks++; if (hs.o_view_card !== 6'h2B) $display("[TB] FAIL ovf_view7: got %h want 2b", hs.o_view_card); else n_passed++;
        tick();
    endtask

    task automatic test_reset_mid_draw();
        logic [2:0] code;
        bit         tmo;
        hb.i_draw_req = 3'b100;
        tick();
        hb.i_draw_req = 3'b000;
        wait_draw_b(code, tmo);
        strobe_b(6'h05);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({hb.o_draw, hb.o_count, hb.o_busy, hb.o_overflow} !== {3'b000, 5'd0, 1'b0, 1'b0})
            $display("[TB] FAIL mid_reset: got draw/count/busy/ovf %b/%0d/%b/%b want 000/0/0/0", hb.o_draw, hb.o_count, hb.o_busy, hb.o_overflow); else n_passed++;
        n_checks++; if ({hs.o_overflow, hs.o_count} !== {1'b0, 4'd0})
            $display("[TB] FAIL mid_reset_ovf: got ovf/count %b/%0d want 0/0", hs.o_overflow, hs.o_count); else n_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_deal();
        test_plays();
        test_draw();
        test_wild();
        test_collision();
        test_overflow();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/uno_player_hand.md
Name: uno_player_hand

Overview:
Per-player card store that consumes cards from the deck block and returns played cards to it. It drives the deck's draw request and captures each card when the deck strobes drawn. It also performs the initial 7-card deal, checks plays for legality against the discard top, and returns each legal card through the deck's insert handshake. Sits between the game controller and the deck, one instance per player.

Parameters:
MAX_CARDS, 24, hand capacity in cards; legal range 8 to 31.
CW, $clog2(MAX_CARDS+1), width of the card count and index.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_deal  in  1  one-cycle pulse: clear hand and deal 7 cards
i_draw_req  in  3  one-hot pulse from controller: 001 draw 1, 010 draw 2, 100 draw 4; other codes are ignored
i_play  in  1  one-cycle pulse: play card at i_sel_idx
i_sel_idx  in  CW  hand slot to play
i_top_card  in  6  current discard top, {color[1:0], value[3:0]}
i_view_idx  in  CW  display read index
i_deck_done  in  1  deck idle
i_deck_drawn  in  1  deck strobe: i_deck_card is valid this cycle
i_deck_card  in  6  card from deck
o_draw  out  3  request code to deck, held during the request
o_insert  out  1  one-cycle pulse to deck: insert o_prev_card
o_prev_card  out  6  played card, valid while o_insert is high
o_play_ok  out  1  one-cycle pulse: play accepted
o_play_reject  out  1  one-cycle pulse: play refused
o_count  out  CW  cards held
o_view_card  out  6  hand[i_view_idx]; 0 if the index is >= count
o_busy  out  1  state is not IDLE
o_uno  out  1  count == 1
o_overflow  out  1  sticky: a card was dropped because the hand was full

Behaviour:
- Card encoding: value 0-9 are numbers, 10 skip, 11 reverse, 12 draw two, 13 wild, 14 wild draw four.
- Reset (async): state IDLE; all hand slots, count, o_draw, o_prev_card and o_overflow cleared; all pulse outputs 0. Reset mid-request drops the request immediately.
- Storage: array hand[0..MAX_CARDS-1] kept packed. Slots 0..count-1 are valid; new cards are appended at slot count.
- State machine: IDLE, REQ, DRAW, PLAY_WAIT.
- IDLE priority in one cycle: i_deal, then i_draw_req, then i_play. A lower-priority i_play in the same cycle gets o_play_reject.
- Requests arriving outside IDLE are ignored. i_play arriving outside IDLE gets o_play_reject.
- i_deal: clears count and o_overflow, then runs sub-requests 100, 010, 001 in order (4+2+1 = 7 cards), each as a full REQ/DRAW pass.
- i_draw_req: latches the code and the needed count (1/2/4), then goes to REQ.
- REQ: o_draw = 0. When i_deck_done is high, next cycle goes to DRAW with o_draw = latched code.
- DRAW: o_draw is held. On each i_deck_drawn: if count < MAX_CARDS, write i_deck_card at slot count and increment count; else drop the card and set o_overflow. Either way, decrement the received-needed counter.
- DRAW exit: on the strobe that brings needed to 0, o_draw becomes 000 the next cycle. Go to REQ for the next deal step, or to IDLE.
- i_deck_drawn outside DRAW is ignored.
- Play legality, evaluated combinationally in IDLE: i_sel_idx < count, and one of: card value >= 13; or card color == top color; or card value == top value. Top cards with value >= 13 match on color only.
- Legal play: o_play_ok pulses the cycle after i_play. hand[sel] is latched into o_prev_card. Slots sel+1..count-1 shift down by one and count decrements, all in the same cycle. Then go to PLAY_WAIT.
- Illegal play: o_play_reject pulses the cycle after i_play; the hand is unchanged.
- PLAY_WAIT: o_insert pulses for one cycle on the first cycle with i_deck_done high, then IDLE. o_prev_card holds its value until the next play.
- o_count, o_uno and o_view_card are combinational from registered state.

Test Plan:
- Reset: assert i_rst_n=0 mid-DRAW -> o_draw=000, o_count=0, o_busy=0, o_overflow=0 within the same cycle.
- Deal: i_deal with the deck strobing 7 cards R3,Y5,G0,B12,R13,Y9,G7 -> o_draw sequence 100,010,001; o_count=7; view idx 3 = 0x3C; o_busy drops after the 7th strobe.
- Legal and illegal plays: top = Y9. Play idx of G7 -> reject, count unchanged. Play idx 5 (Y9) -> o_play_ok, o_insert with o_prev_card=0x19 once i_deck_done=1, count=6, later slots shifted down.
- Wild on wild: top = B13. Play R13 -> accepted. Play G2 -> reject. Play B4 -> accepted.
- Overflow: MAX_CARDS=8, count=7, i_draw_req=100 -> 1 card stored, 3 dropped, o_overflow=1, o_count=8; o_draw released after the 4th strobe.
- Collision and busy: i_draw_req=001 and i_play in the same IDLE cycle -> draw proceeds, o_play_reject=1. i_play while in DRAW -> rejected, hand unchanged.
